// File: rtl/inout_pkg.sv
// Shared constants, state encoding and pair-unpack helper for the in/out index ROM sequencer.
package inout_pkg;

  localparam int NUM_ENTRIES = 128;
  localparam int ADDR_W      = 9;
  localparam int IDX_W       = 8;
  localparam int DATA_W      = 2 * IDX_W;

  localparam logic [ADDR_W-1:0] ENTRIES_A = ADDR_W'(NUM_ENTRIES);
  localparam logic [ADDR_W-1:0] LAST_A    = ADDR_W'(NUM_ENTRIES - 1);

  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t RUN   = 2'd1;
  localparam state_t DRAIN = 2'd2;
  localparam state_t DONE  = 2'd3;

  typedef struct packed {
    logic [IDX_W-1:0] a;
    logic [IDX_W-1:0] b;
  } idx_pair_t;

  // ROM word layout is {idx_a, idx_b}.
  function automatic idx_pair_t unpack_pair(input logic [DATA_W-1:0] word);
    idx_pair_t p;
    p.a = word[DATA_W-1:IDX_W];
    p.b = word[IDX_W-1:0];
    return p;
  endfunction

endpackage

// File: rtl/inout_skid2.sv
// Two-entry synchronous FIFO that catches ROM words already read out while downstream stalls.
module inout_skid2
  import inout_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [1:0]        count,
  output logic [DATA_W-1:0] head
);

  logic [DATA_W-1:0] mem0;
  logic [DATA_W-1:0] mem1;
  logic [1:0]        cnt;

  assign count = cnt;
  assign head  = mem0;

  // mem0 is always the head; a pop shifts mem1 forward.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= 2'd0;
      mem0 <= '0;
      mem1 <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) mem0 <= push_data;
          else             mem1 <= push_data;
          if (cnt != 2'd2) cnt <= cnt + 2'd1;
        end
        2'b01: begin
          mem0 <= mem1;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd2) begin
            mem0 <= mem1;
            mem1 <= push_data;
          end else begin
            mem0 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && !pop && cnt == 2'd2));
    end
  end

endmodule

// File: rtl/inout_seq_ctrl.sv
// Walks the 128-entry index ROM forward or backward and streams unpacked index pairs downstream.
module inout_seq_ctrl
  import inout_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              idx_valid,
  input  logic              idx_ready,
  output logic [IDX_W-1:0]  idx_a,
  output logic [IDX_W-1:0]  idx_b,
  output logic              idx_last,
  output state_t            state_dbg
);

  // Handshake: a pair transfers in any cycle with idx_valid & idx_ready; while
  // idx_valid is high and idx_ready low, idx_a/idx_b/idx_last hold unchanged.

  state_t            state;
  logic              mode_q;
  logic [ADDR_W-1:0] issue_cnt;
  logic [ADDR_W-1:0] pair_cnt;
  logic              inflight;
  logic [1:0]        fifo_count;
  logic [DATA_W-1:0] fifo_head;
  logic              pop;
  logic              issue;
  logic              drain_empty;
  logic [2:0]        occupancy;
  idx_pair_t         head_pair;

  inout_skid2 u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (rom_data),
    .pop       (pop),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  assign idx_valid = (fifo_count != 2'd0);
  assign pop       = idx_valid & idx_ready;
  assign head_pair = unpack_pair(fifo_head);
  assign idx_a     = idx_valid ? head_pair.a : '0;
  assign idx_b     = idx_valid ? head_pair.b : '0;
  assign idx_last  = idx_valid && (pair_cnt == LAST_A);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign state_dbg = state;

  // A word is requested only if a FIFO slot is guaranteed when it lands,
  // since the ROM has no enable and cannot hold its output.
  always_comb begin
    occupancy = 3'(fifo_count) + 3'(inflight) - 3'(pop);
    issue     = (state == RUN) && (issue_cnt != ENTRIES_A) && (occupancy < 3'd2);
  end

  // Leave DRAIN as the final pair pops so done follows it directly.
  assign drain_empty = !inflight &&
                       ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mode_q    <= 1'b0;
      rom_addr  <= '0;
      issue_cnt <= '0;
      pair_cnt  <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= issue;
      if (pop) pair_cnt <= pair_cnt + ADDR_W'(1);
      if (issue) begin
        issue_cnt <= issue_cnt + ADDR_W'(1);
        // Hold on the final address so the counter stays inside 0..127.
        if (issue_cnt != LAST_A) begin
          rom_addr <= mode_q ? rom_addr - ADDR_W'(1) : rom_addr + ADDR_W'(1);
        end
      end
      case (state)
        IDLE: begin
          if (start) begin
            mode_q    <= mode;
            rom_addr  <= mode ? LAST_A : '0;
            issue_cnt <= '0;
            pair_cnt  <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          if (issue_cnt == ENTRIES_A) state <= DRAIN;
        end
        DRAIN: begin
          if (drain_empty) state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inout_seq_ctrl.sv
// Bench for inout_seq_ctrl: table of runs checked against a pair-order model, plus reset corner case.
module tb_inout_seq_ctrl;
  import inout_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              mode;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              idx_valid;
  logic              idx_ready;
  logic [IDX_W-1:0]  idx_a;
  logic [IDX_W-1:0]  idx_b;
  logic              idx_last;
  state_t            state_dbg;

  inout_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .busy      (busy),
    .done      (done),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .idx_valid (idx_valid),
    .idx_ready (idx_ready),
    .idx_a     (idx_a),
    .idx_b     (idx_b),
    .idx_last  (idx_last),
    .state_dbg (state_dbg)
  );

  // clock / ROM model
  always #5 clk = ~clk;

  logic [DATA_W-1:0] rom_mem [NUM_ENTRIES];
  always @(posedge clk) rom_data <= rom_mem[rom_addr[6:0]];

  int tests = 0;
  int fails = 0;
  logic [16:0] exp_q[$];

  typedef struct {
    logic        mode;
    int          ready_kind;   // 0 always ready, 1 random, 2 stall on pair 5
    int          pulse_a;
    int          pulse_b;
    int          exp_first;
    int          exp_done;     // -1: timing not checked
    logic [15:0] exp_first_pair;
    logic [15:0] exp_last_pair;
    logic        rand_rom;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic fill_rom(input logic rnd);
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (rnd) rom_mem[i] = 16'($urandom);
      else     rom_mem[i] = {8'(2 * i), 8'(2 * i + 1)};
    end
  endtask

  // Reference: the run emits every ROM word once, in address order for mode 0
  // and reverse order for mode 1, flagging only the final one as last.
  task automatic build_model(input logic m);
    int addr;
    exp_q.delete();
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      addr = m ? (NUM_ENTRIES - 1 - i) : i;
      exp_q.push_back({rom_mem[addr], (i == NUM_ENTRIES - 1)});
    end
  endtask

  task automatic run(input vec_t v);
    int          cyc;
    int          pops;
    int          stall_cnt;
    int          first_cyc;
    int          done_cyc;
    logic        prev_hold;
    logic [16:0] prev_out;
    logic [16:0] exp;
    logic [15:0] first_pair;
    logic [15:0] last_pair;
    fill_rom(v.rand_rom);
    build_model(v.mode);
    @(posedge clk);
    #1;
    start = 1'b1;
    mode = v.mode;
    idx_ready = 1'b1;
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_valid", idx_valid, 0);
    cyc = 0; pops = 0; stall_cnt = 0; first_cyc = -1; done_cyc = -1;
    prev_hold = 1'b0; prev_out = '0; first_pair = '0; last_pair = '0;
    while (done_cyc < 0 && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
      start = (cyc == v.pulse_a) || (cyc == v.pulse_b);
      mode = start ? ~v.mode : v.mode;
      case (v.ready_kind)
        1: idx_ready = 1'($urandom_range(0, 1));
        2: begin
          if (idx_valid && pops == 5 && stall_cnt < 10) begin
            idx_ready = 1'b0;
            stall_cnt++;
          end else begin
            idx_ready = 1'b1;
          end
        end
        default: idx_ready = 1'b1;
      endcase
      #1;
      if (cyc == 1) chk("first_addr", rom_addr, v.mode ? 127 : 0);
      chk("run_busy", busy, 1);
      chk("addr_hi", rom_addr[8:7], 0);
      if (prev_hold) chk("hold_stable", {idx_valid, idx_a, idx_b, idx_last}, {1'b1, prev_out});
      prev_hold = idx_valid && !idx_ready;
      prev_out = {idx_a, idx_b, idx_last};
      if (idx_valid && idx_ready) begin
        pops++;
        if (first_cyc < 0) begin
          first_cyc = cyc;
          first_pair = {idx_a, idx_b};
        end
        last_pair = {idx_a, idx_b};
        if (exp_q.size() == 0) begin
          chk("extra_pair", pops, NUM_ENTRIES);
        end else begin
          exp = exp_q.pop_front();
          chk("pair", {idx_a, idx_b, idx_last}, exp);
        end
      end
      if (done) done_cyc = cyc;
    end
    start = 1'b0;
    if (done_cyc < 0) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", cyc);
    end
    chk("pairs_total", pops, NUM_ENTRIES);
    chk("model_drained", exp_q.size(), 0);
    if (v.exp_done >= 0) begin
      chk("first_cycle", first_cyc, v.exp_first);
      chk("done_cycle", done_cyc, v.exp_done);
      chk("first_pair", first_pair, v.exp_first_pair);
      chk("last_pair", last_pair, v.exp_last_pair);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    mode = 1'b0;
    idx_ready = 1'b0;
    vecs[0] = '{1'b0, 0, 0, 0, 3, 131, 16'h0001, 16'hFEFF, 1'b0};
    vecs[1] = '{1'b1, 0, 0, 0, 3, 131, 16'hFEFF, 16'h0001, 1'b0};
    vecs[2] = '{1'b0, 2, 0, 0, 3, 141, 16'h0001, 16'hFEFF, 1'b0};
    vecs[3] = '{1'b0, 0, 20, 131, 3, 131, 16'h0001, 16'hFEFF, 1'b0};
    for (int i = 4; i < 9; i++) begin
      vecs[i] = '{1'(i), 1, 0, 0, -1, -1, 16'h0000, 16'h0000, 1'b1};
    end
    fill_rom(1'b0);

    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", idx_valid, 0);
    chk("rst_last", idx_last, 0);
    chk("rst_addr", rom_addr, 0);
    chk("rst_a", idx_a, 0);
    chk("rst_b", idx_b, 0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run(vecs[i]);

    // Reset in cycle 45 of a forward run, then a clean restart.
    fill_rom(1'b0);
    @(posedge clk);
    #1;
    start = 1'b1;
    mode = 1'b0;
    idx_ready = 1'b1;
    for (int c = 1; c <= 45; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", idx_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_addr", rom_addr, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_a", idx_a, 0);
    repeat (3) begin
      @(posedge clk);
      #2;
      chk("post_rst_quiet", {busy, idx_valid}, 0);
    end
    run(vecs[0]);

    @(posedge clk);
    #2;
    chk("final_idle", busy, 0);
    chk("final_valid", idx_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/inout_seq_ctrl.md
Name: inout_seq_ctrl

Overview:
Sequencer for the 128x16 in/out index ROM. Each ROM word packs two 8-bit coefficient indices: {idx_a, idx_b}.
- On start, walks all ROM addresses in forward or reverse order.
- Absorbs the ROM's 1-cycle registered read latency.
- Streams unpacked index pairs over a valid/ready handshake to the NTT coefficient load/unload engine, with full backpressure support.

Parameters:
NUM_ENTRIES, 128, ROM words walked per run
ADDR_W, 9, ROM address width
IDX_W, 8, width of each packed index
DATA_W, 16, ROM word width (2*IDX_W)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  reset, synchronous, active-high
start  in  1  one-cycle run request; honoured only in IDLE
mode  in  1  sampled with start: 0 = addresses 0..127, 1 = addresses 127..0
busy  out  1  high from the cycle after an accepted start through the done cycle
done  out  1  one-cycle pulse after the last pair handshakes
rom_addr  out  ADDR_W  registered ROM address; upper bits always 0
rom_data  in  DATA_W  ROM output, valid 1 cycle after rom_addr is sampled
idx_valid  out  1  pair available
idx_ready  in  1  downstream accepts the pair
idx_a  out  IDX_W  rom_data[15:8] of the current pair
idx_b  out  IDX_W  rom_data[7:0] of the current pair
idx_last  out  1  high with the final pair of the run

Behaviour:
- Reset values: busy=0, done=0, idx_valid=0, idx_last=0, rom_addr=0, idx_a=0, idx_b=0.
- Reset clears the FIFO, in-flight flag and counters, and forces IDLE. This applies mid-run; no pair is emitted after rst.
- States:
  - IDLE: start=1 latches mode, loads the first address, and goes to RUN.
  - RUN: issues addresses. When the issue counter reaches NUM_ENTRIES, go to DRAIN.
  - DRAIN: waits until the FIFO is empty and the in-flight flag is clear, then goes to DONE.
  - DONE: asserts done for 1 cycle, then goes to IDLE.
- start outside IDLE is ignored.
- Issue rule: a new address is issued in a cycle only if (fifo_count + inflight - pop) < 2, where pop = idx_valid & idx_ready.
  - A ROM word is never requested without a guaranteed FIFO slot.
  - There is no ROM enable; a word that has been read out cannot be held.
- inflight=1 in the cycle after an issue. In that cycle rom_data is pushed into the 2-entry FIFO.
- Address counter:
  - mode=0: increments from 0.
  - mode=1: decrements from 127.
  - An ADDR_W-bit counter, but it never leaves 0..127. No wrap occurs, because issuing stops after 128 addresses.
- Pair counter counts pops. idx_last = idx_valid & (pops_so_far == NUM_ENTRIES-1).
- Timing with idx_ready held high, start in cycle 0:
  - rom_addr holds the first address in cycle 1.
  - First idx_valid in cycle 3.
  - 128 pairs on consecutive cycles 3..130; idx_last in cycle 130.
  - done in cycle 131; busy high in cycles 1..131.
- Backpressure:
  - idx_valid, idx_a, idx_b and idx_last stay stable while idx_valid & !idx_ready.
  - No pair is dropped or duplicated.
  - Throughput is 1 pair/cycle whenever ready=1.
- Simultaneous push and pop on a full FIFO is legal; the count is unchanged.
- A push into a full FIFO without a pop cannot occur. This is a verification assertion.

Decomposition:
- Shared package inout_pkg:
  - Constants NUM_ENTRIES, ADDR_W, IDX_W, DATA_W.
  - State enum {IDLE, RUN, DRAIN, DONE}.
  - A helper for unpacking the pair {idx_a, idx_b}.
- One sub-module: inout_skid2, a 2-entry synchronous FIFO.
  - Ports: push, push_data[15:0], pop, count[1:0], head[15:0].
  - Reset on rst.
- Controller FSM, counters and issue logic live in inout_seq_ctrl. The ROM is instantiated outside, at the parent level.

Test Plan:
1. Forward run: rst, start with mode=0, ready=1, ROM word n = {2n, 2n+1}.
   -> Cycle 3: (0,1). Then (2,3) ... (254,255) on cycles 3..130, idx_last at (254,255), done in cycle 131, busy low in cycle 132.
2. Reverse run: start with mode=0... replaced by mode=1.
   -> First pair (254,255), last pair (0,1) with idx_last, 128 pairs total.
3. Stall: ready=0 for 10 cycles starting when pair (10,11) is presented.
   -> (10,11) stable for all 10 cycles, no rom_data lost, next pair (12,13). Total 128 pairs, done 10 cycles later than in scenario 1.
4. Random backpressure: ready random at 50% over 5 runs alternating mode.
   -> Scoreboard matches the exact ordered sequence each run; the FIFO-overflow assertion never fires.
5. start pulsed in cycles 20 and 131 of a forward run.
   -> Both ignored; the run completes normally; a start in cycle 132 (IDLE) begins a new run.
6. rst during cycle 45 of a run.
   -> Next cycle: idx_valid=0, busy=0, rom_addr=0. A subsequent start restarts from (0,1) with the full 128 pairs.
